// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing defaults, RGB222 constants, arm state encoding
// and the per-axis bounce step used by the sprite animator.
package vga_pkg;
  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam logic [5:0] RGB_BLACK = 6'h00;
  localparam logic [5:0] RGB_WHITE = 6'h3F;
  typedef enum logic {ARM_UP = 1'b0, ARM_DOWN = 1'b1} arm_t;
  typedef struct packed {
    logic [10:0] pos;
    logic        dir;
  } axis_t;
  function automatic logic [5:0] fg_map(input logic [5:0] c);
    return c == RGB_BLACK ? RGB_WHITE : c;
  endfunction
  // dir=1 moves toward lim; hitting either edge clamps and reverses
  function automatic axis_t bounce(input logic [10:0] pos, input logic dir,
                                   input logic [10:0] step, input logic [10:0] lim);
    axis_t r;
    logic clamp;
    clamp = dir ? (pos + step >= lim) : (pos <= step);
    r.pos = clamp ? (dir ? lim : 11'd0) : (dir ? pos + step : pos - step);
    r.dir = clamp ? !dir : dir;
    return r;
  endfunction
endpackage

// File: rtl/cat_shape_rom.sv
// cat_shape_rom: combinational cat outline decode on unscaled sprite
// coordinates; the left-arm bar position follows the arm state.
module cat_shape_rom
  import vga_pkg::*;
(
  input  logic [10:0] dx,
  input  logic [10:0] dy,
  input  arm_t        arm,
  output logic        hit
);
  function automatic logic rng(input logic [10:0] v, input logic [10:0] lo, input logic [10:0] hi);
    return v >= lo && v <= hi;
  endfunction
  logic head, ears, eyes, mouth, tongue, body, legs, arms;
  logic [10:0] bar_y;
  assign bar_y  = arm == ARM_UP ? 11'd160 : 11'd180;
  assign head   = rng(dy, 11'd50, 11'd150) && dx <= 11'd150 &&
                  (dx == 11'd0 || dx == 11'd150 || dy == 11'd50 || dy == 11'd150);
  assign ears   = (dx == 11'd25 || dx == 11'd125) && dy <= 11'd50;
  assign eyes   = (dx == 11'd30 || dx == 11'd120) && rng(dy, 11'd90, 11'd95);
  assign mouth  = dy == 11'd120 && rng(dx, 11'd60, 11'd90);
  assign tongue = ((dx == 11'd70 || dx == 11'd80) && rng(dy, 11'd120, 11'd135)) ||
                  (dy == 11'd135 && rng(dx, 11'd70, 11'd80));
  assign body   = rng(dx, 11'd20, 11'd130) && rng(dy, 11'd151, 11'd250) &&
                  (dx == 11'd20 || dx == 11'd130 || dy == 11'd151 || dy == 11'd250);
  assign legs   = ((dx == 11'd40 || dx == 11'd75 || dx == 11'd110) && rng(dy, 11'd251, 11'd300)) ||
                  (dy == 11'd300 && rng(dx, 11'd40, 11'd110));
  assign arms   = ((dx == 11'd140 || dx == 11'd10) && rng(dy, 11'd160, 11'd180)) ||
                  (dy == bar_y && rng(dx, 11'd10, 11'd30));
  assign hit    = head || ears || eyes || mouth || tongue || body || legs || arms;
endmodule

// File: rtl/vga_sprite_animator.sv
// vga_sprite_animator: bouncing, arm-waving cat outline renderer with a
// two-stage pixel pipeline producing registered RGB222.
module vga_sprite_animator
  import vga_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF,
  parameter int SPR_W = 151,
  parameter int SPR_H = 301,
  parameter int SCALE_LOG2 = 0,
  parameter int START_X = 150,
  parameter int START_Y = 50,
  parameter int WAVE_PERIOD = 16,
  parameter logic [5:0] BG_COLOR = 6'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       display_on,
  input  logic [1:0] mode,
  input  logic [1:0] speed,
  input  logic [5:0] fg_color,
  output logic [5:0] rgb,
  output logic       sprite_hit,
  output logic       frame_tick
);
  localparam logic [10:0] LIM_X = 11'(H_RES - (SPR_W << SCALE_LOG2));
  localparam logic [10:0] LIM_Y = 11'(V_RES - (SPR_H << SCALE_LOG2));
  localparam logic [10:0] X0 = 11'(START_X);
  localparam logic [10:0] Y0 = 11'(START_Y);
  localparam int WW = $clog2(WAVE_PERIOD + 1);
  localparam logic [WW-1:0] WAVE_LAST = WW'(WAVE_PERIOD - 1);
  logic [10:0] x_pos, y_pos, x_nxt, y_nxt, step, rel_x, rel_y, dx, dy, s1_dx, s1_dy;
  logic dir_x, dir_y, dir_x_nxt, dir_y_nxt, in_box, s1_in, s1_de, shape_hit, hit;
  logic [WW-1:0] wave_cnt, wave_nxt;
  logic [5:0] fg_q;
  arm_t arm, arm_nxt;
  axis_t ax, ay;
  assign step = 11'(speed) + 11'd1;
  assign ax = bounce(x_pos, dir_x, step, LIM_X);
  assign ay = bounce(y_pos, dir_y, step, LIM_Y);
  // state only changes on the frame_tick cycle, which lies in vertical blanking
  always_comb begin
    x_nxt = x_pos;
    y_nxt = y_pos;
    dir_x_nxt = dir_x;
    dir_y_nxt = dir_y;
    wave_nxt = wave_cnt;
    arm_nxt = arm;
    if (frame_tick && mode != 2'd3) begin
      x_nxt = mode == 2'd0 ? X0 : ax.pos;
      y_nxt = mode == 2'd0 ? Y0 : ay.pos;
      dir_x_nxt = mode == 2'd0 ? 1'b1 : ax.dir;
      dir_y_nxt = mode == 2'd0 ? 1'b1 : ay.dir;
      wave_nxt = (mode != 2'd2 || wave_cnt == WAVE_LAST) ? '0 : wave_cnt + WW'(1);
      arm_nxt = mode != 2'd2 ? ARM_UP : wave_cnt == WAVE_LAST ? arm_t'(~arm) : arm;
    end
  end
  assign rel_x = {1'b0, pix_x} - x_pos;
  assign rel_y = {1'b0, pix_y} - y_pos;
  assign dx = rel_x >> SCALE_LOG2;
  assign dy = rel_y >> SCALE_LOG2;
  assign in_box = {1'b0, pix_x} >= x_pos && {1'b0, pix_y} >= y_pos &&
                  dx < 11'(SPR_W) && dy < 11'(SPR_H);
  cat_shape_rom u_shape (.dx(s1_dx), .dy(s1_dy), .arm(arm), .hit(shape_hit));
  assign hit = s1_de && s1_in && shape_hit;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_pos <= X0;
      y_pos <= Y0;
      dir_x <= 1'b1;
      dir_y <= 1'b1;
      wave_cnt <= '0;
      arm <= ARM_UP;
      fg_q <= RGB_BLACK;
      frame_tick <= 1'b0;
      s1_dx <= '0;
      s1_dy <= '0;
      s1_in <= 1'b0;
      s1_de <= 1'b0;
      rgb <= RGB_BLACK;
      sprite_hit <= 1'b0;
    end else begin
      x_pos <= x_nxt;
      y_pos <= y_nxt;
      dir_x <= dir_x_nxt;
      dir_y <= dir_y_nxt;
      wave_cnt <= wave_nxt;
      arm <= arm_nxt;
      fg_q <= frame_tick ? fg_color : fg_q;
      frame_tick <= pix_x == 10'd0 && pix_y == 10'(V_RES);
      s1_dx <= dx;
      s1_dy <= dy;
      s1_in <= in_box;
      s1_de <= display_on;
      rgb <= !s1_de ? RGB_BLACK : hit ? fg_map(fg_q) : BG_COLOR;
      sprite_hit <= hit;
    end
  end
endmodule

// File: tb/tb_vga_sprite_animator.sv
// tb_vga_sprite_animator: randomized scenarios checked against a segment-list
// model of the cat and a per-frame motion model.
module tb_vga_sprite_animator;
  localparam int WP = 2;
  logic clk = 1'b0;
  logic rst_n;
  logic [9:0] pix_x, pix_y;
  logic display_on;
  logic [1:0] mode, speed;
  logic [5:0] fg_color, rgb;
  logic sprite_hit, frame_tick;
  int checks = 0;
  int failures = 0;
  int mx, my, mwave;
  bit mdx, mdy, m_down;
  logic [5:0] mfg;
  int seg [22][4] = '{
    '{0, 150, 50, 50}, '{0, 150, 150, 150}, '{0, 0, 50, 150}, '{150, 150, 50, 150},
    '{25, 25, 0, 50}, '{125, 125, 0, 50}, '{30, 30, 90, 95}, '{120, 120, 90, 95},
    '{60, 90, 120, 120}, '{70, 70, 120, 135}, '{80, 80, 120, 135}, '{70, 80, 135, 135},
    '{20, 130, 151, 151}, '{20, 130, 250, 250}, '{20, 20, 151, 250}, '{130, 130, 151, 250},
    '{40, 40, 251, 300}, '{75, 75, 251, 300}, '{110, 110, 251, 300}, '{40, 110, 300, 300},
    '{140, 140, 160, 180}, '{10, 10, 160, 180}};

  always #5 clk = ~clk;

  vga_sprite_animator #(.WAVE_PERIOD(WP)) dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .display_on(display_on),
    .mode(mode), .speed(speed), .fg_color(fg_color), .rgb(rgb),
    .sprite_hit(sprite_hit), .frame_tick(frame_tick));

  function automatic bit m_hit(int px, int py, bit de);
    int dx, dy;
    if (!de || px < mx || py < my) return 0;
    dx = px - mx;
    dy = py - my;
    for (int i = 0; i < 22; i++)
      if (dx >= seg[i][0] && dx <= seg[i][1] && dy >= seg[i][2] && dy <= seg[i][3]) return 1;
    return dy == (m_down ? 180 : 160) && dx >= 10 && dx <= 30;
  endfunction

  function automatic logic [5:0] m_rgb(int px, int py, bit de);
    if (!de) return 6'h00;
    if (m_hit(px, py, de)) return mfg == 6'h00 ? 6'h3F : mfg;
    return 6'h00;
  endfunction

  task automatic bounce_axis(inout int p, inout bit d, input int st, input int lim);
    if (d) begin
      if (p + st >= lim) begin p = lim; d = 0; end
      else p += st;
    end else begin
      if (p <= st) begin p = 0; d = 1; end
      else p -= st;
    end
  endtask

  task automatic m_reset();
    mx = 150; my = 50; mdx = 1; mdy = 1; m_down = 0; mwave = 0; mfg = 6'h00;
  endtask

  task automatic m_frame();
    mfg = fg_color;
    if (mode == 2'd3) return;
    if (mode == 2'd0) begin
      mx = 150; my = 50; mdx = 1; mdy = 1;
    end else begin
      bounce_axis(mx, mdx, int'(speed) + 1, 640 - 151);
      bounce_axis(my, mdy, int'(speed) + 1, 480 - 301);
    end
    if (mode == 2'd2) begin
      if (mwave == WP - 1) begin mwave = 0; m_down = !m_down; end
      else mwave++;
    end else begin
      mwave = 0; m_down = 0;
    end
  endtask

  task automatic probe(input int px, input int py, input bit de);
    @(negedge clk);
    pix_x = 10'(px); pix_y = 10'(py); display_on = de;
    @(posedge clk); @(posedge clk); #1;
  endtask

  task automatic frame();
    @(negedge clk);
    pix_x = 10'd0; pix_y = 10'd480; display_on = 1'b0;
    @(negedge clk);
    pix_y = 10'd481;
    @(negedge clk);
    m_frame();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 2'd0; speed = 2'd0; fg_color = 6'h3F;
    pix_x = 10'd150; pix_y = 10'd100; display_on = 1'b1;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rgb, sprite_hit, frame_tick} !== 8'h00) begin
      failures++;
      $display("FAIL reset_hold rgb=%h hit=%b tick=%b want 00/0/0", rgb, sprite_hit, frame_tick);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rgb !== 6'h00) begin
      failures++;
      $display("FAIL reset_refill rgb=%h want 00", rgb);
    end
    @(posedge clk); #1;
    checks++;
    if (rgb !== 6'h3F || sprite_hit !== 1'b1) begin
      failures++;
      $display("FAIL reset_corner rgb=%h hit=%b want 3f/1", rgb, sprite_hit);
    end
    probe(149, 100, 1);
    checks++;
    if (rgb !== 6'h00 || sprite_hit !== 1'b0) begin
      failures++;
      $display("FAIL reset_left_of_box rgb=%h hit=%b want 00/0", rgb, sprite_hit);
    end
  endtask

  task automatic test_frame_tick();
    int xs [4] = '{1, 0, 0, 5};
    int ys [4] = '{480, 479, 480, 480};
    bit want [4] = '{0, 0, 1, 0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pix_x = 10'(xs[i]); pix_y = 10'(ys[i]); display_on = 1'b0;
      @(posedge clk); #1;
      if (i == 3) m_frame();
      checks++;
      if (frame_tick !== want[i]) begin
        failures++;
        $display("FAIL frame_tick x=%0d y=%0d got=%b want=%b", xs[i], ys[i], frame_tick, want[i]);
      end
    end
  endtask

  task automatic test_static();
    int s, px, py;
    mode = 2'd0;
    for (int f = 0; f < 4; f++) begin
      fg_color = 6'($urandom);
      speed = 2'($urandom);
      frame();
      probe(150, 100, 1);
      checks++;
      if (rgb !== m_rgb(150, 100, 1) || sprite_hit !== 1'b1) begin
        failures++;
        $display("FAIL static_corner rgb=%h hit=%b want %h/1", rgb, sprite_hit, m_rgb(150, 100, 1));
      end
      s = $urandom_range(0, 21);
      px = mx + $urandom_range(seg[s][0], seg[s][1]);
      py = my + $urandom_range(seg[s][2], seg[s][3]);
      probe(px, py, 1);
      checks++;
      if (rgb !== m_rgb(px, py, 1) || sprite_hit !== m_hit(px, py, 1)) begin
        failures++;
        $display("FAIL static_seg (%0d,%0d) rgb=%h hit=%b want %h/%b", px, py, rgb, sprite_hit,
                 m_rgb(px, py, 1), m_hit(px, py, 1));
      end
    end
  endtask

  task automatic test_bounce();
    int s, px, py;
    mode = 2'd1;
    for (int f = 0; f < 270; f++) begin
      speed = f < 120 ? 2'd3 : 2'($urandom);
      fg_color = 6'($urandom);
      frame();
      probe(mx, my + 50, 1);
      checks++;
      if (rgb !== m_rgb(mx, my + 50, 1) || sprite_hit !== 1'b1) begin
        failures++;
        $display("FAIL bounce_corner f=%0d pos=(%0d,%0d) rgb=%h hit=%b want %h/1", f, mx, my,
                 rgb, sprite_hit, m_rgb(mx, my + 50, 1));
      end
      s = $urandom_range(0, 21);
      px = mx + $urandom_range(seg[s][0], seg[s][1]);
      py = my + $urandom_range(seg[s][2], seg[s][3]);
      probe(px, py, 1);
      checks++;
      if (rgb !== m_rgb(px, py, 1) || sprite_hit !== m_hit(px, py, 1)) begin
        failures++;
        $display("FAIL bounce_seg (%0d,%0d) rgb=%h hit=%b want %h/%b", px, py, rgb, sprite_hit,
                 m_rgb(px, py, 1), m_hit(px, py, 1));
      end
      px = mx + $urandom_range(0, 155) - 2;
      py = my + $urandom_range(0, 305) - 2;
      if (px < 0) px = 0;
      if (py < 0) py = 0;
      probe(px, py, 1);
      checks++;
      if (rgb !== m_rgb(px, py, 1) || sprite_hit !== m_hit(px, py, 1)) begin
        failures++;
        $display("FAIL bounce_near (%0d,%0d) rgb=%h hit=%b want %h/%b", px, py, rgb, sprite_hit,
                 m_rgb(px, py, 1), m_hit(px, py, 1));
      end
    end
  endtask

  task automatic test_wave();
    mode = 2'd2;
    for (int f = 0; f < 10; f++) begin
      speed = 2'($urandom);
      frame();
      probe(mx + 15, my + 180, 1);
      checks++;
      if (sprite_hit !== m_down || rgb !== m_rgb(mx + 15, my + 180, 1)) begin
        failures++;
        $display("FAIL wave_down f=%0d hit=%b rgb=%h want %b/%h", f, sprite_hit, rgb, m_down,
                 m_rgb(mx + 15, my + 180, 1));
      end
      probe(mx + 15, my + 160, 1);
      checks++;
      if (sprite_hit !== !m_down) begin
        failures++;
        $display("FAIL wave_up f=%0d hit=%b want %b", f, sprite_hit, !m_down);
      end
    end
    mode = 2'd1;
    frame();
    probe(mx + 15, my + 160, 1);
    checks++;
    if (sprite_hit !== 1'b1) begin
      failures++;
      $display("FAIL wave_exit_up hit=%b want 1", sprite_hit);
    end
  endtask

  task automatic test_pause();
    mode = 2'd1; speed = 2'd1;
    frame();
    mode = 2'd3;
    probe(mx, my + 50, 1);
    checks++;
    if (sprite_hit !== 1'b1) begin
      failures++;
      $display("FAIL pause_midframe hit=%b want 1", sprite_hit);
    end
    for (int f = 0; f < 3; f++) begin
      fg_color = 6'($urandom);
      frame();
      probe(mx, my + 50, 1);
      checks++;
      if (sprite_hit !== 1'b1 || rgb !== m_rgb(mx, my + 50, 1)) begin
        failures++;
        $display("FAIL pause_hold f=%0d rgb=%h hit=%b want %h/1", f, rgb, sprite_hit,
                 m_rgb(mx, my + 50, 1));
      end
    end
    probe(0, 0, 1);
    checks++;
    if (sprite_hit !== m_hit(0, 0, 1) || rgb !== m_rgb(0, 0, 1)) begin
      failures++;
      $display("FAIL pause_origin rgb=%h hit=%b want %h/%b", rgb, sprite_hit, m_rgb(0, 0, 1),
               m_hit(0, 0, 1));
    end
  endtask

  task automatic test_display_off();
    int px, py;
    for (int i = 0; i < 12; i++) begin
      px = mx + $urandom_range(0, 150);
      py = my + $urandom_range(0, 300);
      probe(px, py, 0);
      checks++;
      if (rgb !== 6'h00 || sprite_hit !== 1'b0) begin
        failures++;
        $display("FAIL display_off (%0d,%0d) rgb=%h hit=%b want 00/0", px, py, rgb, sprite_hit);
      end
    end
  endtask

  task automatic test_reset_mid();
    mode = 2'd1; speed = 2'd2;
    repeat (3) frame();
    probe(mx, my + 50, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (rgb !== 6'h00 || sprite_hit !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_clear rgb=%h hit=%b want 00/0", rgb, sprite_hit);
    end
    pix_x = 10'd150; pix_y = 10'd100; display_on = 1'b1;
    m_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rgb !== 6'h00) begin
      failures++;
      $display("FAIL reset_mid_refill rgb=%h want 00", rgb);
    end
    @(posedge clk); #1;
    checks++;
    if (rgb !== 6'h3F || sprite_hit !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_start rgb=%h hit=%b want 3f/1", rgb, sprite_hit);
    end
  endtask

  initial begin
    test_reset();
    test_frame_tick();
    test_static();
    test_bounce();
    test_wave();
    test_pause();
    test_display_off();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
